fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and hazard-stall unit for the 5-stage pipeline; sits between decode and execute.
- Generalises the processor's fixed 2-source, 16-bit, EX/WB-only bypass to:
  - N source operands.
  - Configurable data and register widths.
  - Three bypass points: EX, MEM, WB.
  - Variable-latency load results.
- Holds forwarded operands across freezes in registers, and counts stall cycles.

Parameters:
- DATA_W, 16, operand/result width.
- NREGS, 8, architectural register count; AW = clog2(NREGS).
- NSRC, 2, source operands per instruction.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- id_valid  in  1  decode holds a valid instruction.
- id_src_addr  in  NSRC*AW  source register numbers; source i at bits [i*AW +: AW].
- id_src_used  in  NSRC  source i is actually read.
- id_rf_data  in  NSRC*DATA_W  register-file read data.
- ex_wr_en  in  1  EX instruction writes a register.
- ex_wr_addr  in  AW  EX destination register.
- ex_is_load  in  1  EX result comes from data memory.
- ex_data  in  DATA_W  EX ALU result.
- mem_wr_en  in  1  MEM instruction writes a register.
- mem_wr_addr  in  AW  MEM destination register.
- mem_is_load  in  1  MEM instruction is a load.
- mem_rdy  in  1  MEM load data valid this cycle.
- mem_data  in  DATA_W  MEM result (ALU or load).
- wb_wr_en  in  1  WB writes the register file.
- wb_wr_addr  in  AW  WB destination register.
- wb_data  in  DATA_W  WB write data.
- pipe_stall  in  1  global freeze (I-mem/D-mem busy).
- flush  in  1  branch/jump flush of decode.
- op_data  out  NSRC*DATA_W  resolved operands to execute.
- hz_stall  out  1  load-use stall request to fetch/decode.
- stall_cnt  out  CNT_W  saturating count of hz_stall cycles.
- err  out  1  protocol error, sticky until reset.

Behaviour:
- Reset (rst=0, async) clears:
  - hold_valid[], hold_data[] to 0.
  - stall_cnt to 0.
  - err to 0.
- op_data and hz_stall are combinational; with id_valid=0 they evaluate to rf data and 0.
- Per-source select, for used sources, highest priority first:
  1. hold_valid[i]: hold_data[i].
  2. EX match (ex_wr_en, addr equal, ex_is_load=0): ex_data.
  3. MEM match, not a load or mem_rdy=1: mem_data.
  4. WB match: wb_data.
  5. Otherwise: id_rf_data[i].
  - A match takes the youngest producer.
  - Register 0 is an ordinary register, with no zero special case.
- hz_stall = id_valid and, for any used source i, either:
  - EX match with ex_is_load=1; or
  - MEM match with mem_is_load=1 and mem_rdy=0, and no younger EX match.
  - hz_stall is asserted for every cycle the load latency lasts.
- Hold registers (decode held = hz_stall or pipe_stall):
  - Source not stalled and not yet held: each cycle decode is held, capture the selected value into hold_data[i] and set hold_valid[i].
  - Source already held: a later WB or MEM forward to the same address is not possible, since the producer is older. The captured value stays frozen.
  - Clear on the cycle decode advances (id_valid and no hold): hold_valid[] goes to 0 at the next edge.
  - flush clears hold_valid[] at the next edge and has priority over capture.
- Stall counter: increments on each cycle with hz_stall=1 and pipe_stall=0; saturates at all-ones and does not wrap.
- err sets on any of:
  - mem_rdy=1 with mem_is_load=0.
  - Two hold captures of a source whose stalled-producer condition is still true.

Decomposition:
- Shared package fwd_pkg holds:
  - Select encoding constants: SEL_RF, SEL_WB, SEL_MEM, SEL_EX, SEL_HOLD.
  - The AW computation function.
- One sub-module, fwd_src_mux: per-source match, priority select and hold register, instantiated NSRC times by generate.
- The top level ORs the per-source stall requests and owns the counter and err.

Test Plan:
- EX bypass: ex_wr_en=1, ex_wr_addr=3, ex_data=0x1234, src0=r3 used → op_data[0]=0x1234, hz_stall=0.
- Priority: EX writes r2=0xAAAA, MEM writes r2=0xBBBB, WB writes r2=0xCCCC → src=r2 gets 0xAAAA.
  - Drop EX → 0xBBBB.
  - Drop MEM → 0xCCCC.
- Load-use, variable latency:
  - EX load to r5, src1=r5 → hz_stall=1.
  - Next cycle in MEM with mem_rdy=0 for 3 cycles → hz_stall stays 1.
  - mem_rdy=1 with mem_data=0x0F0F → op_data[1]=0x0F0F, hz_stall=0.
  - stall_cnt=4.
- Hold across freeze:
  - pipe_stall=1 while WB forwards r1=0x5555 to src0; WB then retires.
  - rf still 0x0000 → op_data[0] remains 0x5555 until release.
  - hold_valid clears one cycle after decode advances.
- Flush and reset:
  - Assert flush during a held stall → hold_valid clears and op_data reverts to rf data.
  - Pull rst low mid-stall → stall_cnt=0, err=0 immediately, without waiting for a clock.
- Error and saturation:
  - mem_rdy=1 with mem_is_load=0 → err=1, sticky.
  - With CNT_W=4, hold 20 stall cycles → stall_cnt=15.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package fwd_pkg;

  localparam logic [2:0] SEL_RF   = 3'd0;
  localparam logic [2:0] SEL_WB   = 3'd1;
  localparam logic [2:0] SEL_MEM  = 3'd2;
  localparam logic [2:0] SEL_EX   = 3'd3;
  localparam logic [2:0] SEL_HOLD = 3'd4;

  // Register-number width. Kept at least 1 bit so a 1- or 2-entry file still has an address.
  function automatic int calc_aw(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

endpackage

// File: rtl/fwd_src_mux.sv
// One source operand: producer match, priority bypass select, stall request and hold register.
module fwd_src_mux
  import fwd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              src_used,
  input  logic [AW-1:0]     src_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wr_en,
  input  logic [AW-1:0]     ex_wr_addr,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_wr_en,
  input  logic [AW-1:0]     mem_wr_addr,
  input  logic              mem_is_load,
  input  logic              mem_rdy,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_wr_en,
  input  logic [AW-1:0]     wb_wr_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              dec_hold,
  input  logic              flush,
  output logic [DATA_W-1:0] op_data,
  output logic              stall_req,
  output logic              err_req
);

  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              ex_hit, mem_hit, wb_hit, active;
  logic [2:0]        sel;

  // Match producers, pick the youngest usable one, and flag a load-use stall.
  always_comb begin
    ex_hit  = ex_wr_en  && (ex_wr_addr  == src_addr);
    mem_hit = mem_wr_en && (mem_wr_addr == src_addr);
    wb_hit  = wb_wr_en  && (wb_wr_addr  == src_addr);
    active  = id_valid && src_used;

    // A younger EX match shadows MEM even when EX is the pending load.
    stall_req = active && ((ex_hit && ex_is_load) ||
                           (!ex_hit && mem_hit && mem_is_load && !mem_rdy));
    // A held value that now sees a stalled producer means the capture was stale.
    err_req   = hold_valid_q && stall_req;

    sel = SEL_RF;
    if (active) begin
      if (hold_valid_q)  sel = SEL_HOLD;
      else if (ex_hit)   sel = ex_is_load ? SEL_RF : SEL_EX;
      else if (mem_hit)  sel = (!mem_is_load || mem_rdy) ? SEL_MEM : SEL_RF;
      else if (wb_hit)   sel = SEL_WB;
    end

    case (sel)
      SEL_HOLD: op_data = hold_data_q;
      SEL_EX:   op_data = ex_data;
      SEL_MEM:  op_data = mem_data;
      SEL_WB:   op_data = wb_data;
      default:  op_data = rf_data;
    endcase
  end

  // Hold register next state: flush wins, then advance clears, then capture while frozen.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (flush) begin
      hold_valid_d = 1'b0;
    end else if (id_valid && !dec_hold) begin
      hold_valid_d = 1'b0;
    end else if (dec_hold && active && !stall_req && !hold_valid_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = op_data;
    end
  end

  // Hold register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit between decode and execute.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [NSRC*AW-1:0]     id_src_addr,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic [NSRC*DATA_W-1:0] id_rf_data,
  input  logic                   ex_wr_en,
  input  logic [AW-1:0]          ex_wr_addr,
  input  logic                   ex_is_load,
  input  logic [DATA_W-1:0]      ex_data,
  input  logic                   mem_wr_en,
  input  logic [AW-1:0]          mem_wr_addr,
  input  logic                   mem_is_load,
  input  logic                   mem_rdy,
  input  logic [DATA_W-1:0]      mem_data,
  input  logic                   wb_wr_en,
  input  logic [AW-1:0]          wb_wr_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   pipe_stall,
  input  logic                   flush,
  output logic [NSRC*DATA_W-1:0] op_data,
  output logic                   hz_stall,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic                   err
);

  logic [NSRC-1:0]  src_stall, src_err;
  logic             dec_hold;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    fwd_src_mux #(.DATA_W(DATA_W), .AW(AW)) u_src (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .src_used    (id_src_used[g]),
      .src_addr    (id_src_addr[g*AW +: AW]),
      .rf_data     (id_rf_data[g*DATA_W +: DATA_W]),
      .ex_wr_en    (ex_wr_en),
      .ex_wr_addr  (ex_wr_addr),
      .ex_is_load  (ex_is_load),
      .ex_data     (ex_data),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_is_load (mem_is_load),
      .mem_rdy     (mem_rdy),
      .mem_data    (mem_data),
      .wb_wr_en    (wb_wr_en),
      .wb_wr_addr  (wb_wr_addr),
      .wb_data     (wb_data),
      .dec_hold    (dec_hold),
      .flush       (flush),
      .op_data     (op_data[g*DATA_W +: DATA_W]),
      .stall_req   (src_stall[g]),
      .err_req     (src_err[g])
    );
  end

  // Combine per-source requests; compute saturating counter and sticky error next state.
  always_comb begin
    hz_stall    = |src_stall;
    dec_hold    = hz_stall || pipe_stall;
    stall_cnt_d = stall_cnt_q;
    if (hz_stall && !pipe_stall && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    err_d = err_q || (mem_rdy && !mem_is_load) || (|src_err);
  end

  // Counter and error state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: bypass priority, load-use stalls, hold, flush, reset, error, saturation.
module tb_fwd_hazard_unit;

  logic        clk, rst;
  logic        id_valid;
  logic [5:0]  id_src_addr;
  logic [1:0]  id_src_used;
  logic [31:0] id_rf_data;
  logic        ex_wr_en, ex_is_load;
  logic [2:0]  ex_wr_addr;
  logic [15:0] ex_data;
  logic        mem_wr_en, mem_is_load, mem_rdy;
  logic [2:0]  mem_wr_addr;
  logic [15:0] mem_data;
  logic        wb_wr_en;
  logic [2:0]  wb_wr_addr;
  logic [15:0] wb_data;
  logic        pipe_stall, flush;
  logic [31:0] op_data, op_data_s;
  logic        hz_stall, hz_stall_s, err, err_s;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int tests_run = 0;
  int tests_failed = 0;

  fwd_hazard_unit u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rf_data(id_rf_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_is_load(mem_is_load),
    .mem_rdy(mem_rdy), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
    .pipe_stall(pipe_stall), .flush(flush),
    .op_data(op_data), .hz_stall(hz_stall), .stall_cnt(stall_cnt), .err(err)
  );

  fwd_hazard_unit #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_rf_data(id_rf_data),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_is_load(mem_is_load),
    .mem_rdy(mem_rdy), .mem_data(mem_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_data(wb_data),
    .pipe_stall(pipe_stall), .flush(flush),
    .op_data(op_data_s), .hz_stall(hz_stall_s), .stall_cnt(stall_cnt_s), .err(err_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src_addr = '0; id_src_used = '0; id_rf_data = '0;
    ex_wr_en = 0; ex_wr_addr = '0; ex_is_load = 0; ex_data = '0;
    mem_wr_en = 0; mem_wr_addr = '0; mem_is_load = 0; mem_rdy = 0; mem_data = '0;
    wb_wr_en = 0; wb_wr_addr = '0; wb_data = '0;
    pipe_stall = 0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #12;
    check("reset_cnt", 32'(stall_cnt), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_hz", 32'(hz_stall), 32'd0);
    rst = 1'b1;
    step();

    // EX bypass
    id_valid = 1; id_src_used = 2'b01; id_src_addr = {3'd0, 3'd3}; id_rf_data = 32'h9999_8888;
    ex_wr_en = 1; ex_wr_addr = 3'd3; ex_data = 16'h1234;
    #1;
    check("ex_bypass", 32'(op_data[15:0]), 32'h1234);
    check("ex_bypass_hz", 32'(hz_stall), 32'd0);
    check("unused_src1_rf", 32'(op_data[31:16]), 32'h9999);

    // Priority EX > MEM > WB > RF
    id_src_addr = {3'd0, 3'd2};
    ex_wr_addr = 3'd2; ex_data = 16'hAAAA;
    mem_wr_en = 1; mem_wr_addr = 3'd2; mem_data = 16'hBBBB;
    wb_wr_en = 1; wb_wr_addr = 3'd2; wb_data = 16'hCCCC;
    #1; check("prio_ex", 32'(op_data[15:0]), 32'hAAAA);
    ex_wr_en = 0;
    #1; check("prio_mem", 32'(op_data[15:0]), 32'hBBBB);
    mem_wr_en = 0;
    #1; check("prio_wb", 32'(op_data[15:0]), 32'hCCCC);
    wb_wr_en = 0;
    #1; check("prio_rf", 32'(op_data[15:0]), 32'h8888);

    // Register 0 forwards like any other register
    id_src_addr = {3'd0, 3'd0}; ex_wr_en = 1; ex_wr_addr = 3'd0; ex_data = 16'h0BAD;
    #1; check("r0_bypass", 32'(op_data[15:0]), 32'h0BAD);
    id_valid = 0;
    #1; check("invalid_rf", 32'(op_data[15:0]), 32'h8888);
    step();
    idle();

    // Load-use with variable memory latency
    id_valid = 1; id_src_used = 2'b10; id_src_addr = {3'd5, 3'd0}; id_rf_data = 32'h2222_0000;
    ex_wr_en = 1; ex_wr_addr = 3'd5; ex_is_load = 1; ex_data = 16'hDEAD;
    #1; check("lu_ex_hz", 32'(hz_stall), 32'd1);
    step();
    ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_addr = 3'd5; mem_is_load = 1; mem_rdy = 0; mem_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      #1; check("lu_mem_wait_hz", 32'(hz_stall), 32'd1);
      step();
    end
    mem_rdy = 1; mem_data = 16'h0F0F;
    #1;
    check("lu_data", 32'(op_data[31:16]), 32'h0F0F);
    check("lu_release_hz", 32'(hz_stall), 32'd0);
    check("lu_cnt", 32'(stall_cnt), 32'd4);
    step();
    idle();

    // Hold across a global freeze
    id_valid = 1; id_src_used = 2'b01; id_src_addr = {3'd0, 3'd1}; id_rf_data = '0;
    wb_wr_en = 1; wb_wr_addr = 3'd1; wb_data = 16'h5555; pipe_stall = 1;
    #1; check("hold_wb_fwd", 32'(op_data[15:0]), 32'h5555);
    step();
    wb_wr_en = 0;
    #1; check("hold_after_wb", 32'(op_data[15:0]), 32'h5555);
    step();
    check("hold_frozen", 32'(op_data[15:0]), 32'h5555);
    pipe_stall = 0;
    #1; check("hold_release_cycle", 32'(op_data[15:0]), 32'h5555);
    step();
    check("hold_cleared", 32'(op_data[15:0]), 32'h0000);
    check("hold_no_count", 32'(stall_cnt), 32'd4);
    idle();
    step();

    // Flush drops a held operand
    id_valid = 1; id_src_used = 2'b10; id_src_addr = {3'd4, 3'd0}; id_rf_data = 32'h1111_0000;
    wb_wr_en = 1; wb_wr_addr = 3'd4; wb_data = 16'h7777; pipe_stall = 1;
    step();
    wb_wr_en = 0;
    #1; check("flush_pre_hold", 32'(op_data[31:16]), 32'h7777);
    flush = 1;
    step();
    flush = 0;
    #1; check("flush_reverts", 32'(op_data[31:16]), 32'h1111);
    idle();
    step();
    check("no_err_yet", 32'(err), 32'd0);

    // Protocol error is sticky
    mem_rdy = 1; mem_is_load = 0;
    step();
    check("err_set", 32'(err), 32'd1);
    idle();
    step();
    check("err_sticky", 32'(err), 32'd1);

    // 20 stall cycles: 16-bit counter 4 -> 24, 4-bit counter saturates at 15
    id_valid = 1; id_src_used = 2'b01; id_src_addr = {3'd0, 3'd6};
    ex_wr_en = 1; ex_wr_addr = 3'd6; ex_is_load = 1;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", 32'(stall_cnt_s), 32'd15);
    check("cnt16", 32'(stall_cnt), 32'd24);
    check("sat_hz", 32'(hz_stall_s), 32'd1);
    check("sat_err", 32'(err_s), 32'd1);
    check("sat_op_rf", 32'(op_data_s[15:0]), 32'h0000);

    // Asynchronous reset mid-stall
    #2 rst = 1'b0;
    #1;
    check("async_rst_cnt", 32'(stall_cnt), 32'd0);
    check("async_rst_err", 32'(err), 32'd0);
    check("async_rst_cnt4", 32'(stall_cnt_s), 32'd0);
    idle();
    step();
    rst = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
